// File: rtl/dec_three_eight_pulse_pkg.sv
// ----------------------------------------------------------------------------
// dec_three_eight_pulse_pkg
// Shared definitions for the registered 3:8 pulse decoder.
//   CODE_W            width of the {a,b,c} code
//   ST_IDLE/DRIVE/GAP FSM state encodings (legacy numeric values kept)
// ----------------------------------------------------------------------------
package dec_three_eight_pulse_pkg;

    localparam int unsigned CODE_W = 3;
    localparam int unsigned ST_W   = 2;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_DRIVE = 2'd1;
    localparam logic [ST_W-1:0] ST_GAP   = 2'd2;

endpackage

// File: rtl/dec_three_eight_comb.sv
// ----------------------------------------------------------------------------
// dec_three_eight_comb
// Pure combinational 3:8 decoder.
//   code_i   [2:0]  binary code, bit 2 = MSB
//   onehot_o [7:0]  onehot_o[k] = 1 when code_i == k
// ----------------------------------------------------------------------------
module dec_three_eight_comb
    import dec_three_eight_pulse_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [7:0]        onehot_o
);

    always_comb begin
        onehot_o = 8'd1 << code_i;
    end

endmodule

// File: rtl/dec_three_eight_pulse.sv
// ----------------------------------------------------------------------------
// dec_three_eight_pulse
// Registered 3:8 decoder with valid/ready input and timed one-hot pulses.
// One accepted code drives y one-hot for PULSE_LEN cycles, then y = 0 for
// GAP_LEN cycles before the next code can be taken.
//   clk       rising-edge clock
//   rst_n     synchronous, active-low reset
//   a,b,c     code bits 2,1,0
//   in_valid  {a,b,c} holds a code
//   in_ready  high in IDLE, code accepted when in_valid & in_ready
//   y[7:0]    registered one-hot output
//   busy      high in DRIVE or GAP
//   done      one-cycle pulse in the first cycle after y returns to 0
// ----------------------------------------------------------------------------
module dec_three_eight_pulse
    import dec_three_eight_pulse_pkg::*;
#(
    parameter int unsigned PULSE_LEN     = 4,
    parameter int unsigned GAP_LEN       = 2,
    parameter bit          ZERO_SUPPRESS = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] y,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] P_RELOAD = CNT_W'(PULSE_LEN - 1);
    // GAP_LEN == 0 never enters GAP, so its reload value is irrelevant there.
    localparam logic [CNT_W-1:0] G_RELOAD = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;

    logic [ST_W-1:0]   state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [7:0]        y_q,     y_d;
    logic              done_q,  done_d;
    logic [CODE_W-1:0] code_in;
    logic [7:0]        dec_onehot;

    assign code_in = {a, b, c};

    dec_three_eight_comb u_dec (
        .code_i   (code_in),
        .onehot_o (dec_onehot)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_DRIVE;
                    cnt_d   = P_RELOAD;
                    // Suppressed code 0 still runs the full timing, only y stays 0.
                    y_d     = (ZERO_SUPPRESS && (code_in == '0)) ? '0 : dec_onehot;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == '0) begin
                    y_d    = '0;
                    done_d = 1'b1;
                    if (GAP_LEN == 0) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = G_RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                y_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign y        = y_q;
    assign done     = done_q;

endmodule

// File: tb/tb_dec_three_eight_pulse.sv
// ----------------------------------------------------------------------------
// tb_dec_three_eight_pulse
// Two decoder instances share one stimulus stream:
//   dut0: PULSE_LEN=4, GAP_LEN=2, ZERO_SUPPRESS=1
//   dut1: PULSE_LEN=1, GAP_LEN=0, ZERO_SUPPRESS=0
// The reference tracks, per instance, how many edges have passed since the
// last accepted code and derives all outputs from that age.
// ----------------------------------------------------------------------------
module tb_dec_three_eight_pulse;

    localparam int INF = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a = 1'b0, b = 1'b0, c = 1'b0;
    logic       in_valid = 1'b0;
    logic       rdy0, busy0, done0, rdy1, busy1, done1;
    logic [7:0] y0, y1;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    int         PL [2] = '{4, 1};
    int         GL [2] = '{2, 0};
    bit         ZS [2] = '{1'b1, 1'b0};
    int         age [2] = '{INF, INF};
    logic [2:0] code_m [2];

    int  cyc = 0;
    int  prev_acc [2] = '{-1, -1};

    always #5 clk = ~clk;

    dec_three_eight_pulse #(.PULSE_LEN(4), .GAP_LEN(2), .ZERO_SUPPRESS(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .in_valid(in_valid),
        .in_ready(rdy0), .y(y0), .busy(busy0), .done(done0)
    );

    dec_three_eight_pulse #(.PULSE_LEN(1), .GAP_LEN(0), .ZERO_SUPPRESS(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .in_valid(in_valid),
        .in_ready(rdy1), .y(y1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_y(input int i);
        if (age[i] < PL[i] && !(ZS[i] && code_m[i] == 3'd0))
            return 8'd1 << code_m[i];
        return 8'h00;
    endfunction

    function automatic bit exp_ready(input int i);
        return age[i] >= PL[i] + GL[i];
    endfunction

    // Reference update: ready is judged from the age before this edge.
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                age[i] = INF;
            end else if (in_valid && exp_ready(i)) begin
                age[i]    = 0;
                code_m[i] = {a, b, c};
            end else if (age[i] < INF) begin
                age[i] = age[i] + 1;
            end
        end
    end

    // Accept spacing under continuously held valid, measured on the DUTs.
    always @(posedge clk) begin
        if (!rst_n || !in_valid) begin
            prev_acc[0] = -1;
            prev_acc[1] = -1;
        end else begin
            if (rdy0) begin
                if (prev_acc[0] >= 0) chk("spacing0", 8'(cyc - prev_acc[0]), 8'd7);
                prev_acc[0] = cyc;
            end
            if (rdy1) begin
                if (prev_acc[1] >= 0) chk("spacing1", 8'(cyc - prev_acc[1]), 8'd2);
                prev_acc[1] = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("y0",     y0,          exp_y(0));
            chk("done0",  8'(done0),   8'(age[0] == PL[0]));
            chk("busy0",  8'(busy0),   8'(!exp_ready(0)));
            chk("ready0", 8'(rdy0),    8'(exp_ready(0)));
            chk("y1",     y1,          exp_y(1));
            chk("done1",  8'(done1),   8'(age[1] == PL[1]));
            chk("busy1",  8'(busy1),   8'(!exp_ready(1)));
            chk("ready1", 8'(rdy1),    8'(exp_ready(1)));
        end
    end

    // Called at a negedge; returns at the negedge after dut0 accepts.
    task automatic send(input logic [2:0] code, input bit drop);
        {a, b, c} = code;
        in_valid  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (rdy0) begin
                @(posedge clk);
                @(negedge clk);
                if (drop) in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("accept_timeout", 8'd0, 8'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] sweep_exp [8] = '{8'h00, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    initial begin
        // Reset held 3 edges with valid asserted.
        in_valid = 1'b1;
        {a, b, c} = 3'd5;
        repeat (3) @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_y0", y0, 8'h00);
        chk("rst_busy0", 8'(busy0), 8'd0);
        chk("rst_done0", 8'(done0), 8'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready0", 8'(rdy0), 8'd1);
        idle(2);

        // Code 5 with default timing.
        send(3'd5, 1'b1);
        chk("code5_y0", y0, 8'h20);
        repeat (3) @(negedge clk);
        chk("code5_y0_last", y0, 8'h20);
        @(negedge clk);
        chk("code5_done0", 8'(done0), 8'd1);
        chk("code5_y0_off", y0, 8'h00);
        idle(8);

        // Back-to-back sweep 0..7.
        for (int k = 0; k < 8; k++) begin
            send(3'(k), 1'b0);
            chk("sweep_y0", y0, sweep_exp[k]);
            if (k == 0) chk("sweep_y1_code0", y1, 8'h01);
        end
        idle(10);

        // Code changes during DRIVE are ignored.
        send(3'd3, 1'b0);
        {a, b, c} = 3'd6;
        repeat (3) @(negedge clk);
        chk("hold_y0", y0, 8'h08);
        send(3'd6, 1'b1);
        chk("next_y0", y0, 8'h40);
        idle(10);

        // Reset during the 2nd DRIVE cycle of code 7.
        send(3'd7, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_y0", y0, 8'h00);
        chk("midrst_done0", 8'(done0), 8'd0);
        chk("midrst_busy0", 8'(busy0), 8'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_done0_after", 8'(done0), 8'd0);
        idle(3);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            {a, b, c} = 3'($urandom_range(0, 7));
            rst_n     = ($urandom_range(0, 59) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
